// File: rtl/input_capture_pkg.sv
// input_capture_pkg: shared register encodings and limits for the input capture bank
package input_capture_pkg;
  localparam int MAX_CHANNELS = 8;
  typedef enum logic [1:0] {REG_STATE, REG_PRESSED, REG_RELEASED, REG_COUNT} rd_reg_e;
endpackage

// File: rtl/input_debounce_ch.sv
// input_debounce_ch: one channel of per-bit debounce, edge latches and saturating press counter
module input_debounce_ch #(
  parameter int WIDTH    = 32,
  parameter int DB_BITS  = 3,
  parameter int CNT_BITS = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_sample,
  input  logic [WIDTH-1:0]    raw,
  input  logic                clear_pressed,
  input  logic                clear_released,
  output logic [WIDTH-1:0]    stable,
  output logic [WIDTH-1:0]    pressed,
  output logic [WIDTH-1:0]    released,
  output logic [CNT_BITS-1:0] count
);
  localparam int DB_MAX = 2**DB_BITS - 1;
  localparam int SW = CNT_BITS + $clog2(WIDTH + 1);
  localparam logic [SW-1:0] CMAX = SW'(2**CNT_BITS - 1);
  logic [DB_BITS-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] flip, rise, fall;
  logic [SW-1:0] sum;
  logic [CNT_BITS-1:0] count_nxt;
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++)
      flip[i] = ce_sample && (raw[i] != stable[i]) && (cnt[i] == DB_BITS'(DB_MAX - 1));
    rise = flip & raw;
    fall = flip & ~raw;
    sum = SW'(count) + SW'($countones(rise));
    count_nxt = sum > CMAX ? CMAX[CNT_BITS-1:0] : sum[CNT_BITS-1:0];
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stable   <= '0;
      pressed  <= '0;
      released <= '0;
      count    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable   <= stable ^ flip;
      pressed  <= (clear_pressed ? '0 : pressed) | rise;
      released <= (clear_released ? '0 : released) | fall;
      count    <= count_nxt;
      for (int i = 0; i < WIDTH; i++)
        if (ce_sample) cnt[i] <= (raw[i] == stable[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
endmodule

// File: rtl/input_capture_bank.sv
// input_capture_bank: multi-channel debounced input capture with clear-on-read latches, counters and irq
module input_capture_bank
  import input_capture_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DB_BITS  = 3,
  parameter int CNT_BITS = 8
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         ce_sample,
  input  logic [CHANNELS*WIDTH-1:0]    joy_in,
  input  logic                         rd_en,
  input  logic [$clog2(MAX_CHANNELS)-1:0] rd_chan,
  input  logic [1:0]                   rd_reg,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [CHANNELS*WIDTH-1:0]    stable,
  output logic                         irq
);
  logic [WIDTH-1:0] st [CHANNELS];
  logic [WIDTH-1:0] pr [CHANNELS];
  logic [WIDTH-1:0] rl [CHANNELS];
  logic [CNT_BITS-1:0] ct [CHANNELS];
  logic in_range, any;
  logic [WIDTH-1:0] rd_mux;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    input_debounce_ch #(.WIDTH(WIDTH), .DB_BITS(DB_BITS), .CNT_BITS(CNT_BITS)) u_ch (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ce_sample      (ce_sample),
      .raw            (joy_in[c*WIDTH +: WIDTH]),
      .clear_pressed  (rd_en && rd_chan == 3'(c) && rd_reg == REG_PRESSED),
      .clear_released (rd_en && rd_chan == 3'(c) && rd_reg == REG_RELEASED),
      .stable         (st[c]),
      .pressed        (pr[c]),
      .released       (rl[c]),
      .count          (ct[c])
    );
    assign stable[c*WIDTH +: WIDTH] = st[c];
  end
  always_comb begin
    in_range = 32'(rd_chan) < CHANNELS;
    rd_mux = !in_range                ? '0 :
             rd_reg == REG_STATE      ? st[rd_chan] :
             rd_reg == REG_PRESSED    ? pr[rd_chan] :
             rd_reg == REG_RELEASED   ? rl[rd_chan] : WIDTH'(ct[rd_chan]);
    any = 1'b0;
    for (int c = 0; c < CHANNELS; c++) any = any | (|pr[c]) | (|rl[c]);
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_data  <= rd_en ? rd_mux : '0;
      rd_valid <= rd_en;
      irq      <= any;
    end
  end
endmodule
